fxp_mult_arbiter: RTL
=====================

# fxp_mult_arbiter

Shared-resource controller for the team's Q2.2 unsigned fixed-point multiply. Two requesters compete for one sequential shift-and-add multiplier. Grants alternate round-robin, the W-cycle multiply is sequenced by a small FSM, and the aligned product is returned with the winner's ID over a valid/ready response port. It sits between the HW1 datapath clients and any downstream consumer that needs Q2.2 products without instantiating a combinational multiplier per client.

## Interface
- W, 4, operand width in bits (unsigned, Q(W-FRAC).FRAC)
- FRAC, 2, fractional bits per operand; product is realigned by right shift of FRAC
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has operands
- req0_a  input  W  requester 0 operand A
- req0_b  input  W  requester 0 operand B
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that owns the result
- rsp_product  output  2W  ((A*B) >> FRAC), zero-extended to 2W

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - reqN_ready is combinational. req0_ready = IDLE & req0_valid & (prio==0 | !req1_valid). req1_ready mirrors it with roles swapped.
  - At most one ready is high.
  - Accept = reqN_valid & reqN_ready at a clock edge. On accept, latch A, B, and id; clear the accumulator and bit counter; go to MUL.
- MUL lasts exactly W cycles, one multiplier bit per cycle, LSB first:
  - If b[cnt]==1, acc += A << cnt.
  - acc is 2W bits wide. No overflow is possible, since max (2^W-1)^2 < 2^(2W).
  - After count W-1, go to RESP.
- RESP:
  - rsp_valid = 1, rsp_product = acc >> FRAC (upper FRAC bits zero), rsp_id = latched id.
  - All three are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE.
- Round-robin: prio register. On accepting from requester N, prio <= ~N. So after serving 0, requester 1 wins the next contention, and vice versa. A lone requester always wins regardless of prio.
- Requests arriving while in MUL or RESP are not accepted. Requesters must hold valid and operands until ready.
- Truncation: fractional bits below 2^-FRAC are dropped (floor). No rounding, no saturation.

## Timing
- Reset values:
  - state=IDLE, prio=0, acc=0, cnt=0, id=0.
  - rsp_valid=0, rsp_product=0, rsp_id=0.
  - req0_ready=req1_ready=0 while rst is high.
- Latency: with accept at edge 0, MUL occupies cycles 1..W and rsp_valid is high from cycle W+1. For W=4 the response is in cycle 5.
- Throughput: one result per W+2 cycles at best. The IDLE cycle after the response handshake is the earliest next accept.
- rsp_ready low stalls indefinitely in RESP; requester ready stays 0 throughout.
- rsp_ready high during MUL has no effect.
- rst asserted in any state returns to reset values at the next edge. An in-flight operation is discarded and no response is produced.
- Simultaneous valid on both requesters with prio=0 grants req0 only; req1_ready stays 0 that cycle.

## Test plan
- Single request, W=4, FRAC=2: req0 A=4'b0110 (1.5), B=4'b1010 (2.5) -> rsp_valid in cycle 5, rsp_product=8'h0F (3.75), rsp_id=0.
- Extremes: A=B=4'hF -> 8'h38. A=4'h0, B=4'hF -> 8'h00. A=4'h1, B=4'h1 -> 8'h00 (0.25*0.25 floors to 0).
- Contention: both valid from reset, req0 (A=4, B=4), req1 (A=8, B=8) -> first rsp id=0 product 8'h04, second rsp id=1 product 8'h10. Then both valid again -> req0 is served next (prio alternates).
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_product, and rsp_id stable. req0_ready and req1_ready stay 0. Releasing rsp_ready gives IDLE on the next cycle.
- Reset mid-MUL: assert rst in cycle 2 after accept -> next cycle all outputs at reset values, no response. prio=0, so with both valid req0 is granted.
- Random sweep of all 256 operand pairs alternating requesters -> every rsp_product == (A*B)>>2 with the correct rsp_id, no dropped or duplicated results.

Source files
------------

// File: rtl/fxp_mult_arbiter.sv
// rtl/fxp_mult_arbiter.sv - round-robin arbiter in front of one sequential Q2.2 shift-and-add multiplier
// Two requesters share the multiplier; the product is returned with the winner's id over a valid/ready port.
module fxp_mult_arbiter #(
    parameter int W    = 4,
    parameter int FRAC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_product
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    state_t         state;
    logic           prio;
    logic           id;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] partial;
    logic [2*W-1:0] acc_next;
    logic [CW-1:0]  cnt;
    logic           grant0;
    logic           grant1;

    // prio names the requester that wins when both are valid; a lone requester always wins
    assign grant0 = !rst && (state == IDLE) && req0_valid && (!prio || !req1_valid);
    assign grant1 = !rst && (state == IDLE) && req1_valid && (prio || !req0_valid);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign partial  = b_reg[cnt] ? ({{W{1'b0}}, a_reg} << cnt) : '0;
    assign acc_next = acc + partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            id          <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_reg <= grant0 ? req0_a : req1_a;
                        b_reg <= grant0 ? req0_b : req1_b;
                        id    <= grant1;
                        prio  <= grant0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // last multiplier bit: publish the realigned (floored) product directly
                    if (cnt == CW'(W - 1)) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= id;
                        rsp_product <= acc_next >> FRAC;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
